// File: rtl/orpsoc_rst_seq.sv
// orpsoc_rst_seq: multi-domain reset sequencer for the SoC top level.
// Async assert, synchronised and staggered release, timed warm reset.
// Ports:
//   wb_clk_i       system clock
//   wb_rst_n_i     async active-low external / power-on reset
//   soft_rst_req_i warm reset request (level, sync to wb_clk_i)
//   rst_o          per-channel active-high reset
//   done_o         all channels released
//   cause_o        last cause: 01 external, 10 soft
//   soft_cnt_o     saturating count of accepted soft resets
module orpsoc_rst_seq #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter logic [NUM_CH*CNT_W-1:0] CH_DELAY =
    {8'd16, 8'd8, 8'd0},
  parameter int HOLD_CYCLES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              soft_rst_req_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              done_o,
  output logic [1:0]        cause_o,
  output logic [7:0]        soft_cnt_o
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_SEQ,
    S_RUN,
    S_SOFT
  } state_t;

  function automatic logic [CNT_W-1:0] f_max(
    input logic [NUM_CH*CNT_W-1:0] d
  );
    logic [CNT_W-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (d[k*CNT_W +: CNT_W] > m) m = d[k*CNT_W +: CNT_W];
    end
    return m;
  endfunction

  localparam logic [CNT_W-1:0] MAX_D  = f_max(CH_DELAY);
  localparam logic [CNT_W-1:0] LIM    =
    {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_M1 =
    CNT_W'(HOLD_CYCLES - 1);
  localparam bit P_OK =
    (NUM_CH >= 1) && (NUM_CH <= 8) &&
    (SYNC_STAGES >= 2) &&
    (HOLD_CYCLES >= 1) &&
    (HOLD_CYCLES < (2 ** CNT_W)) &&
    (MAX_D <= LIM);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_CH-1:0]      r_rst;
  logic                   r_done;
  logic [1:0]             r_cause;
  logic [7:0]             r_soft_cnt;

  logic                   w_rst_sync;
  logic                   w_soft;
  state_t                 w_state_nx;
  logic [CNT_W-1:0]       w_cnt_nx;
  logic [NUM_CH-1:0]      w_rst_nx;
  logic                   w_done_nx;
  logic [1:0]             w_cause_nx;
  logic [7:0]             w_scnt_nx;

  assign w_rst_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_sync     <= '0;
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_rst      <= '1;
      r_done     <= 1'b0;
      r_cause    <= 2'b01;
      r_soft_cnt <= 8'd0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_rst      <= w_rst_nx;
      r_done     <= w_done_nx;
      r_cause    <= w_cause_nx;
      r_soft_cnt <= w_scnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rst_nx   = r_rst;
    w_done_nx  = r_done;
    w_cause_nx = r_cause;
    w_scnt_nx  = r_soft_cnt;
    w_soft     = 1'b0;
    unique case (r_state)
      S_HOLD: begin
        if (w_rst_sync) begin
          w_state_nx = S_SEQ;
          w_cnt_nx   = '0;
        end
      end
      S_SEQ: begin
        w_cnt_nx = r_cnt + CNT_W'(1);
        for (int k = 0; k < NUM_CH; k++) begin
          if (r_cnt == CH_DELAY[k*CNT_W +: CNT_W])
            w_rst_nx[k] = 1'b0;
        end
        // The RUN-entry edge completes; a pending
        // request is taken on the following edge.
        if (r_cnt == MAX_D) begin
          w_state_nx = S_RUN;
          w_done_nx  = 1'b1;
        end else if (soft_rst_req_i) begin
          w_soft = 1'b1;
        end
      end
      S_RUN: begin
        if (soft_rst_req_i) w_soft = 1'b1;
      end
      S_SOFT: begin
        if (r_cnt < HOLD_C) w_cnt_nx = r_cnt + CNT_W'(1);
        if ((r_cnt >= HOLD_M1) && !soft_rst_req_i) begin
          w_state_nx = S_SEQ;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = S_HOLD;
        w_cnt_nx   = '0;
      end
    endcase
    if (w_soft) begin
      w_state_nx = S_SOFT;
      w_cnt_nx   = '0;
      w_rst_nx   = '1;
      w_done_nx  = 1'b0;
      w_cause_nx = 2'b10;
      if (r_soft_cnt != 8'hFF)
        w_scnt_nx = r_soft_cnt + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    assert (P_OK)
      else $error("orpsoc_rst_seq: illegal parameters");
  end

  assign rst_o      = r_rst;
  assign done_o     = r_done;
  assign cause_o    = r_cause;
  assign soft_cnt_o = r_soft_cnt;

endmodule

// File: tb/tb_orpsoc_rst_seq.sv
// tb_orpsoc_rst_seq: directed bench for orpsoc_rst_seq.
// Default instance plus a 1-channel, 3-stage sync instance.
module tb_orpsoc_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [2:0] rst;
  logic       done;
  logic [1:0] cause;
  logic [7:0] scnt;

  logic       rst2_n;
  logic       req2;
  logic [0:0] rst2;
  logic       done2;
  logic [1:0] cause2;
  logic [7:0] scnt2;

  int n_chk;
  int n_err;
  int D [3] = '{0, 8, 16};

  orpsoc_rst_seq u_dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .soft_rst_req_i(req),
    .rst_o         (rst),
    .done_o        (done),
    .cause_o       (cause),
    .soft_cnt_o    (scnt)
  );

  orpsoc_rst_seq #(
    .NUM_CH     (1),
    .SYNC_STAGES(3),
    .CH_DELAY   (8'd0)
  ) u_dut1 (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst2_n),
    .soft_rst_req_i(req2),
    .rst_o         (rst2),
    .done_o        (done2),
    .cause_o       (cause2),
    .soft_cnt_o    (scnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // j counts edges from a reference edge; channel k
  // is expected low from edge base+D[k] onwards.
  task automatic run_chk(input int base, input int n,
                         input int rel);
    logic [2:0] e;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk);
      #1;
      if (j == rel) req = 1'b0;
      for (int k = 0; k < 3; k++) e[k] = (j < base + D[k]);
      check($sformatf("rst_o b%0d j%0d", base, j),
            32'(rst), 32'(e));
      check($sformatf("done_o b%0d j%0d", base, j),
            32'(done), 32'(j >= base + 16));
    end
  endtask

  task automatic chk_soft(input logic [7:0] cnt);
    check("soft rst_o", 32'(rst), 32'h7);
    check("soft done_o", 32'(done), 32'h0);
    check("soft cause_o", 32'(cause), 32'h2);
    check("soft cnt", 32'(scnt), 32'(cnt));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    req    = 1'b0;
    rst2_n = 1'b0;
    req2   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst rst_o", 32'(rst), 32'h7);
    check("rst done_o", 32'(done), 32'h0);
    check("rst cause_o", 32'(cause), 32'h1);
    check("rst soft_cnt", 32'(scnt), 32'h0);

    // power-on
    rst_n = 1'b1;
    run_chk(4, 22, -1);
    check("po cause_o", 32'(cause), 32'h1);

    // async reset between edges 8 and 9
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_chk(4, 8, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst_o", 32'(rst), 32'h7);
    check("async done_o", 32'(done), 32'h0);
    check("async cause_o", 32'(cause), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_chk(4, 22, -1);

    // one-cycle soft pulse in RUN
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk_soft(8'd1);
    run_chk(5, 22, -1);
    check("short cause_o", 32'(cause), 32'h2);

    // long soft request, 20 sampled-high edges
    req = 1'b1;
    @(posedge clk);
    #1;
    chk_soft(8'd2);
    run_chk(21, 40, 19);

    // soft request in SEQ with counter = 5
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk_soft(8'd3);
    run_chk(5, 9, -1);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk_soft(8'd4);
    run_chk(5, 22, -1);

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      if (i == 250) check("cnt 255", 32'(scnt), 32'hFF);
    end
    check("cnt sat", 32'(scnt), 32'hFF);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk_soft(8'hFF);

    // async reset in the middle of SOFT
    #2;
    rst_n = 1'b0;
    #1;
    check("soft-rst rst_o", 32'(rst), 32'h7);
    check("soft-rst done_o", 32'(done), 32'h0);
    check("soft-rst cause_o", 32'(cause), 32'h1);
    check("soft-rst cnt", 32'(scnt), 32'h0);

    // one channel, zero delay, three sync stages
    @(posedge clk);
    #1;
    check("cfg rst0", 32'(rst2), 32'h1);
    rst2_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("cfg rst_o j%0d", j),
            32'(rst2), 32'(j < 5));
      check($sformatf("cfg done_o j%0d", j),
            32'(done2), 32'(j >= 5));
    end
    check("cfg cause_o", 32'(cause2), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
